// File: rtl/mem_scan_ctrl.sv
// Strided memory scan sequencer: issues synchronous reads over a configured
// address range and streams the returned words out through a 2-entry skid FIFO.
module mem_scan_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_en_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] strideBytes_q, strideBytes_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflightLast_q, inflightLast_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              headLast_q, headLast_d;
    logic              tailLast_q, tailLast_d;
    logic [1:0]        count_q, count_d;

    logic       startAccept;
    logic       handshake;
    logic       lastIssue;
    logic       finalHs;
    logic [1:0] pending;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign out_last_o  = out_valid_o && headLast_q;
    assign mem_addr_o  = addr_q;
    assign done_o      = done_q;

    assign startAccept = (state_q == IDLE) && start_i && !abort_i;
    assign handshake   = out_valid_o && out_ready_i;
    assign finalHs     = handshake && out_last_o;
    assign pending     = count_q + {1'b0, inflight_q};
    assign lastIssue   = mem_en_o && (remaining_q == LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startAccept && (cfg_len_i != '0)) state_d = RUN;
            RUN:     if (lastIssue) state_d = DRAIN;
            DRAIN:   if (finalHs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    // A pop this cycle frees a slot, so issuing stays legal even at full occupancy.
    always_comb begin
        busy_o   = (state_q != IDLE);
        mem_en_o = (state_q == RUN) && ((pending < 2'd2) || handshake);
    end

    always_comb begin
        addr_d         = addr_q;
        strideBytes_d  = strideBytes_q;
        remaining_d    = remaining_q;
        inflight_d     = mem_en_o && !abort_i;
        inflightLast_d = lastIssue;
        done_d         = !abort_i &&
                         ((startAccept && (cfg_len_i == '0)) ||
                          ((state_q == DRAIN) && finalHs));
        if (startAccept) begin
            addr_d        = cfg_addr_i;
            strideBytes_d = cfg_stride_i * INC;
            remaining_d   = cfg_len_i;
        end else if (mem_en_o) begin
            addr_d      = addr_q + strideBytes_q;
            remaining_d = remaining_q - LEN_W'(1);
        end
    end

    // Head entry drives the stream directly; tail only fills while the head stalls.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        headLast_d = headLast_q;
        tailLast_d = tailLast_q;
        count_d    = count_q;
        if (abort_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (inflight_q) begin
                        head_d     = mem_data_i;
                        headLast_d = inflightLast_q;
                        count_d    = 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight_q && handshake) begin
                        head_d     = mem_data_i;
                        headLast_d = inflightLast_q;
                    end else if (inflight_q) begin
                        tail_d     = mem_data_i;
                        tailLast_d = inflightLast_q;
                        count_d    = 2'd2;
                    end else if (handshake) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (handshake) begin
                        head_d     = tail_q;
                        headLast_d = tailLast_q;
                        if (inflight_q) begin
                            tail_d     = mem_data_i;
                            tailLast_d = inflightLast_q;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q         <= '0;
            strideBytes_q  <= '0;
            remaining_q    <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
            head_q         <= '0;
            tail_q         <= '0;
            headLast_q     <= 1'b0;
            tailLast_q     <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            addr_q         <= addr_d;
            strideBytes_q  <= strideBytes_d;
            remaining_q    <= remaining_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            headLast_q     <= headLast_d;
            tailLast_q     <= tailLast_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench for mem_scan_ctrl: expected reads and stream words are queued
// at start time and consumed by a negedge monitor as the DUT presents them.
module tb_mem_scan_ctrl;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 10;
    localparam int LEN_W     = 16;
    localparam int INC       = DATA_W / 8;
    localparam int MEM_WORDS = (1 << ADDR_W) / INC;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } item_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [ADDR_W-1:0] cfg_addr_i = '0;
    logic [LEN_W-1:0]  cfg_len_i = '0;
    logic [ADDR_W-1:0] cfg_stride_i = '0;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_en_o;
    logic [DATA_W-1:0] mem_data_i = '0;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;
    logic              out_ready_i;

    logic [DATA_W-1:0] memArr [MEM_WORDS];
    item_t expQ[$];
    int    addrQ[$];

    int checks = 0;
    int errors = 0;
    bit busyExp = 1'b0;
    bit doneExp = 1'b0;
    bit startPending = 1'b0;
    bit abortPending = 1'b0;
    int startLen = 0;
    bit monEnable = 1'b0;
    int readyMode = 0;
    int readyPhase = 0;

    mem_scan_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_stride_i(cfg_stride_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_addr_o  (mem_addr_o),
        .mem_en_o    (mem_en_o),
        .mem_data_i  (mem_data_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read memory; returns noise whenever no read was issued.
    always @(posedge clk_i) begin
        if (mem_en_o) mem_data_i <= memArr[mem_addr_o[ADDR_W-1:2]];
        else          mem_data_i <= DATA_W'($urandom);
    end

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ((readyPhase % 4) == 0) || ((readyPhase % 4) == 3);
                2:       out_ready_i = 1'($urandom_range(1, 0));
                default: out_ready_i = 1'b0;
            endcase
            readyPhase++;
        end
    end

    // Monitor: compares this cycle's outputs, then advances the model's busy/done view.
    always @(negedge clk_i) begin
        bit    nextBusy;
        bit    nextDone;
        item_t front;
        int    ea;
        if (monEnable) begin
            checks++;
            if (busy_o !== busyExp) begin
                errors++;
                $display("[TB] FAIL busy t=%0t: got %b expected %b", $time, busy_o, busyExp);
            end
            checks++;
            if (done_o !== doneExp) begin
                errors++;
                $display("[TB] FAIL done t=%0t: got %b expected %b", $time, done_o, doneExp);
            end
            nextBusy = busyExp;
            nextDone = 1'b0;
            if (mem_en_o) begin
                checks++;
                if (addrQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL read_addr t=%0t: got read at %h, expected no read", $time, mem_addr_o);
                end else begin
                    ea = addrQ.pop_front();
                    if (mem_addr_o !== ADDR_W'(ea)) begin
                        errors++;
                        $display("[TB] FAIL read_addr t=%0t: got %h expected %h", $time, mem_addr_o, ADDR_W'(ea));
                    end
                end
            end
            if (out_valid_o) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stream t=%0t: got valid data %h, expected no valid", $time, out_data_o);
                end else begin
                    front = expQ[0];
                    if ((out_data_o !== front.data) || (out_last_o !== front.last)) begin
                        errors++;
                        $display("[TB] FAIL stream t=%0t: got data %h last %b, expected data %h last %b",
                                 $time, out_data_o, out_last_o, front.data, front.last);
                    end
                    if (out_ready_i) begin
                        front = expQ.pop_front();
                        if (front.last) begin
                            nextBusy = 1'b0;
                            nextDone = 1'b1;
                        end
                    end
                end
            end
            if (startPending) begin
                nextBusy     = (startLen != 0);
                nextDone     = (startLen == 0);
                startPending = 1'b0;
            end
            if (abortPending) begin
                expQ.delete();
                addrQ.delete();
                nextBusy     = 1'b0;
                nextDone     = 1'b0;
                abortPending = 1'b0;
            end
            busyExp = nextBusy;
            doneExp = nextDone;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expVal);
        checks++;
        if (got !== expVal) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: got %0h expected %0h", name, $time, got, expVal);
        end
    endtask

    // Drives start for one cycle; if the model says the block is idle, queues the scan.
    task automatic applyStimulus(input int addr, input int len, input int stride);
        start_i      = 1'b1;
        cfg_addr_i   = ADDR_W'(addr);
        cfg_len_i    = LEN_W'(len);
        cfg_stride_i = ADDR_W'(stride);
        if (!busyExp && !abort_i) begin
            startPending = 1'b1;
            startLen     = len;
            for (int i = 0; i < len; i++) begin
                int    a;
                item_t it;
                a       = (addr + i * stride * INC) % (1 << ADDR_W);
                it.data = memArr[a / INC];
                it.last = (i == len - 1);
                addrQ.push_back(a);
                expQ.push_back(it);
            end
        end
        tick();
        start_i      = 1'b0;
        cfg_addr_i   = ADDR_W'($urandom);
        cfg_len_i    = LEN_W'($urandom);
        cfg_stride_i = ADDR_W'($urandom);
    endtask

    task automatic applyAbort();
        abort_i      = 1'b1;
        abortPending = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while ((busyExp || doneExp || startPending || (expQ.size() != 0)) && (n < maxCycles)) begin
            tick();
            n++;
        end
        if (n >= maxCycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout t=%0t: got still busy after %0d cycles, expected idle", $time, n);
        end
        tick();
        tick();
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_busy"},  busy_o,      1'b0);
        checkOutput({tag, "_done"},  done_o,      1'b0);
        checkOutput({tag, "_en"},    mem_en_o,    1'b0);
        checkOutput({tag, "_valid"}, out_valid_o, 1'b0);
        checkOutput({tag, "_last"},  out_last_o,  1'b0);
        checkOutput({tag, "_addr"},  mem_addr_o,  '0);
        checkOutput({tag, "_data"},  out_data_o,  '0);
    endtask

    initial begin
        logic [7:0] tEn, tValid, tLast, tDone, tBusy;
        for (int w = 0; w < MEM_WORDS; w++) memArr[w] = DATA_W'($urandom);

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkAllReset("reset");
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        monEnable = 1'b1;
        tick();

        // Latency and throughput with ready held high: cycle-exact table
        tEn    = 8'b0001_1110;
        tValid = 8'b0111_1000;
        tLast  = 8'b0100_0000;
        tDone  = 8'b1000_0000;
        tBusy  = 8'b0111_1110;
        readyMode = 0;
        applyStimulus(32'h10, 4, 1);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("lat_en_c%0d", c),    mem_en_o,    tEn[c]);
            checkOutput($sformatf("lat_valid_c%0d", c), out_valid_o, tValid[c]);
            checkOutput($sformatf("lat_last_c%0d", c),  out_last_o,  tLast[c]);
            checkOutput($sformatf("lat_done_c%0d", c),  done_o,      tDone[c]);
            checkOutput($sformatf("lat_busy_c%0d", c),  busy_o,      tBusy[c]);
            tick();
        end
        waitIdle(50);

        // Backpressure pattern 1,0,0,1
        readyMode  = 1;
        readyPhase = 0;
        applyStimulus(32'h10, 4, 1);
        waitIdle(100);
        readyMode = 0;
        tick();

        // Zero-length scan: done pulse only
        applyStimulus(32'h44, 0, 1);
        @(negedge clk_i);
        checkOutput("len0_done", done_o,   1'b1);
        checkOutput("len0_en",   mem_en_o, 1'b0);
        tick();
        waitIdle(20);

        // Address wrap at the top of the byte space
        applyStimulus(32'h3F8, 3, 2);
        waitIdle(50);

        // Abort in cycle 4 of a stalled scan, then a clean restart
        readyMode = 3;
        tick();
        tick();
        applyStimulus(32'h40, 8, 1);
        repeat (3) tick();
        applyAbort();
        @(negedge clk_i);
        checkOutput("abort_busy",  busy_o,      1'b0);
        checkOutput("abort_valid", out_valid_o, 1'b0);
        checkOutput("abort_done",  done_o,      1'b0);
        readyMode = 0;
        tick();
        waitIdle(10);
        applyStimulus(32'h100, 5, 3);
        waitIdle(50);

        // Start while busy is ignored
        applyStimulus(32'h20, 6, 1);
        tick();
        applyStimulus(32'h200, 3, 5);
        waitIdle(50);

        // Asynchronous reset in the middle of a scan
        readyMode = 2;
        applyStimulus(32'h80, 10, 1);
        tick();
        tick();
        #2;
        rst_i     = 1'b1;
        monEnable = 1'b0;
        #1;
        checkAllReset("midrst");
        expQ.delete();
        addrQ.delete();
        busyExp      = 1'b0;
        doneExp      = 1'b0;
        startPending = 1'b0;
        abortPending = 1'b0;
        tick();
        tick();
        rst_i     = 1'b0;
        monEnable = 1'b1;
        tick();

        // Long scan exercising the counters beyond 8 bits
        readyMode = 1;
        applyStimulus($urandom_range(1023, 0), 300, $urandom_range(1023, 0));
        waitIdle(1500);

        // Randomized scans with stalls, stray starts and aborts
        for (int it = 0; it < 40; it++) begin
            int len;
            int addr;
            int stride;
            readyMode = $urandom_range(2, 0);
            len       = $urandom_range(12, 0);
            addr      = $urandom_range(1023, 0);
            stride    = ((it % 8) == 0) ? 0 : $urandom_range(1023, 0);
            applyStimulus(addr, len, stride);
            if ($urandom_range(3, 0) == 0) begin
                repeat ($urandom_range(4, 1)) tick();
                applyStimulus($urandom_range(1023, 0), $urandom_range(6, 0), $urandom_range(1023, 0));
            end
            if ($urandom_range(4, 0) == 0) begin
                repeat ($urandom_range(6, 0)) tick();
                applyAbort();
            end
            waitIdle(300);
        end

        @(negedge clk_i);
        checkOutput("final_busy",  busy_o,      1'b0);
        checkOutput("final_valid", out_valid_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_scan_ctrl.md
Name: mem_scan_ctrl

Overview:
Sequencer that drives one synchronous-read memory port over a configured address range and streams the words out on a valid/ready interface. Software or an upstream FSM loads start address, element count and stride, then pulses start. The block issues reads, absorbs the 1-cycle read latency in a 2-entry buffer so downstream backpressure never loses data, and flags the last element and completion. It sits between a unit's local memory and the consuming datapath.

Parameters:
DATA_W, 32, memory/stream data width; byte increment per word INC = DATA_W/8
ADDR_W, 10, memory byte-address width
LEN_W, 16, element-count width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  begin scan; config sampled this cycle; ignored while busy_o=1
abort_i  in  1  cancel scan in progress
cfg_addr_i  in  ADDR_W  first byte address
cfg_len_i  in  LEN_W  number of elements
cfg_stride_i  in  ADDR_W  stride in words
busy_o  out  1  scan active
done_o  out  1  one-cycle completion pulse
mem_addr_o  out  ADDR_W  read byte address
mem_en_o  out  1  read enable
mem_data_i  in  DATA_W  read data, valid the cycle after mem_en_o=1
out_valid_o  out  1  stream valid
out_data_o  out  DATA_W  stream data
out_last_o  out  1  current element is final one
out_ready_i  in  1  stream ready

Behaviour:
- Reset: busy_o, done_o, mem_en_o, out_valid_o, out_last_o = 0; mem_addr_o = 0; out_data_o = 0; buffer empty; state IDLE.
- States: IDLE -> RUN on start_i with cfg_len_i != 0; IDLE -> IDLE with done_o pulse next cycle when start_i and cfg_len_i == 0 (no reads, no stream output). RUN -> DRAIN when last read issued; DRAIN -> IDLE when final element handshaken; done_o = 1 for the cycle after that handshake, busy_o = 0 in that same cycle.
- busy_o = 1 in RUN and DRAIN.
- Issue rule: mem_en_o = 1 in RUN when (buffer occupancy + reads in flight) < 2, or when an output handshake (out_valid_o & out_ready_i) occurs this cycle. mem_en_o depends combinationally on out_ready_i.
- Address: first read uses cfg_addr_i; each issued read advances mem_addr_o by cfg_stride_i * INC, truncated to ADDR_W (wraps modulo 2^ADDR_W). Stride 0 rereads the same address.
- Latency: start_i high in cycle 0 -> mem_en_o in cycle 1 -> data captured into buffer at end of cycle 2 -> out_valid_o in cycle 3.
- Throughput: with out_ready_i held high, one element per cycle after first; no bubbles.
- Buffer: 2-entry FIFO, registered output. out_data_o and out_last_o stay stable while out_valid_o & !out_ready_i. Never overflows, by the issue rule.
- out_last_o = 1 only with the element whose index is cfg_len_i-1.
- abort_i (any state): next cycle state IDLE, buffer flushed, out_valid_o = 0, in-flight read data discarded, no done_o. abort_i has priority over a simultaneous start_i.
- start_i while busy_o = 1: ignored, config unchanged.
- Element counters are LEN_W wide; cfg_len_i = 2^LEN_W-1 is supported.
- rst_i mid-scan: immediate return to reset values.

Test Plan:
- addr=0x10, len=4, stride=1, DATA_W=32, ready=1 -> reads 0x10,0x14,0x18,0x1C in cycles 1-4; valid cycles 3-6; last in cycle 6; done cycle 7.
- Same config, ready toggling 1,0,0,1,... -> all 4 words delivered in order, none dropped or duplicated; mem_en_o stalls when occupancy+inflight = 2; data held stable while stalled.
- len=0 start -> no mem_en_o, no out_valid_o, done_o pulse cycle 1.
- addr=0x3F8 (ADDR_W=10), stride=2, len=3 -> addresses 0x3F8, 0x000, 0x008 (wrap).
- abort_i in cycle 4 of len=8 scan with ready=0 -> cycle 5: busy_o = 0, out_valid_o = 0, no done_o; a new start afterwards runs cleanly from its own cfg_addr_i.
- start_i pulsed again mid-scan with different config -> ignored; original sequence and done timing unchanged.
